// File: rtl/alu_unit_pipe.sv
// LAT-stage pipelined integer ALU between issue and the result bus / ROB.
// Carries Pw and the ROB tag with each result and flags dest-p0 / signed overflow.
module alu_unit_pipe #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned PREG_W  = 5,
  parameter int unsigned TAG_W   = 5,
  parameter int unsigned LAT     = 2,
  parameter bit          EXC_OVF = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              freeze_back,
  input  logic              valid_in,
  input  logic [2:0]        op_in,
  input  logic [PREG_W-1:0] Pw_in,
  input  logic [DATA_W-1:0] busA_in,
  input  logic [DATA_W-1:0] busB_in,
  input  logic [TAG_W-1:0]  tag_ROB_in,
  output logic              ready_in,
  output logic              busy,
  output logic              valid_Result,
  output logic [PREG_W-1:0] Pw_Result,
  output logic [DATA_W-1:0] Result,
  output logic              exp_Result,
  output logic [1:0]        exp_code,
  output logic [TAG_W-1:0]  tag_ROB_Result
);

  localparam int unsigned ShW = $clog2(DATA_W);

  typedef struct packed {
    logic              valid;
    logic [1:0]        code;
    logic [PREG_W-1:0] pw;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] res;
  } stage_t;

  stage_t [LAT-1:0] stage_q, stage_d;
  stage_t           s1;
  logic [DATA_W-1:0] res;
  logic              ovf;
  logic              a_msb, b_msb;

  assign a_msb = busA_in[DATA_W-1];
  assign b_msb = busB_in[DATA_W-1];

  always_comb begin
    res = '0;
    ovf = 1'b0;
    case (op_in)
      3'd0: begin
        res = busA_in + busB_in;
        ovf = (a_msb == b_msb) && (res[DATA_W-1] != a_msb);
      end
      3'd1: begin
        res = busA_in - busB_in;
        ovf = (a_msb != b_msb) && (res[DATA_W-1] != a_msb);
      end
      3'd2:    res = busA_in & busB_in;
      3'd3:    res = busA_in | busB_in;
      3'd4:    res = busA_in ^ busB_in;
      3'd5:    res = {{(DATA_W-1){1'b0}}, ($signed(busA_in) < $signed(busB_in))};
      3'd6:    res = busA_in << busB_in[ShW-1:0];
      default: res = busA_in >> busB_in[ShW-1:0];
    endcase
  end

  // Dest-p0 outranks overflow; bubbles never carry an exception.
  always_comb begin
    s1       = '0;
    s1.valid = valid_in;
    s1.pw    = Pw_in;
    s1.tag   = tag_ROB_in;
    s1.res   = res;
    if (valid_in && (Pw_in == '0)) begin
      s1.code = 2'd1;
    end else if (EXC_OVF && valid_in && ovf) begin
      s1.code = 2'd2;
    end
  end

  always_comb begin
    stage_d = stage_q;
    if (flush) begin
      stage_d = '0;
    end else if (!freeze_back) begin
      stage_d[0] = s1;
      for (int i = 1; i < int'(LAT); i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < int'(LAT); i++) begin
      busy = busy | stage_q[i].valid;
    end
  end

  assign ready_in       = !freeze_back;
  assign valid_Result   = stage_q[LAT-1].valid;
  assign Pw_Result      = stage_q[LAT-1].pw;
  assign Result         = stage_q[LAT-1].res;
  assign exp_code       = stage_q[LAT-1].code;
  assign exp_Result     = (stage_q[LAT-1].code != 2'd0);
  assign tag_ROB_Result = stage_q[LAT-1].tag;

endmodule

// File: tb/tb_alu_unit_pipe.sv
// Bench for alu_unit_pipe: vector table plus scoreboard, and hand-written
// freeze / flush / async-reset sequences.
module tb_alu_unit_pipe;

  localparam int unsigned Lat  = 2;
  localparam int unsigned NVec = 16;
  localparam logic [2:0] OpAdd = 3'd0, OpSub = 3'd1, OpAnd = 3'd2, OpOr  = 3'd3;
  localparam logic [2:0] OpXor = 3'd4, OpSlt = 3'd5, OpSll = 3'd6, OpSrl = 3'd7;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        freeze_back = 1'b0;
  logic        valid_in = 1'b0;
  logic [2:0]  op_in = '0;
  logic [4:0]  Pw_in = '0;
  logic [15:0] busA_in = '0;
  logic [15:0] busB_in = '0;
  logic [4:0]  tag_ROB_in = '0;

  logic        ready_in, busy, valid_Result, exp_Result;
  logic [4:0]  Pw_Result, tag_ROB_Result;
  logic [15:0] Result;
  logic [1:0]  exp_code;

  logic        n_ready, n_busy, n_valid, n_exp;
  logic [4:0]  n_pw, n_tag;
  logic [15:0] n_res;
  logic [1:0]  n_code;

  alu_unit_pipe #(.DATA_W(16), .PREG_W(5), .TAG_W(5), .LAT(Lat), .EXC_OVF(1'b1)) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .freeze_back(freeze_back), .valid_in(valid_in),
    .op_in(op_in), .Pw_in(Pw_in), .busA_in(busA_in), .busB_in(busB_in),
    .tag_ROB_in(tag_ROB_in), .ready_in(ready_in), .busy(busy), .valid_Result(valid_Result),
    .Pw_Result(Pw_Result), .Result(Result), .exp_Result(exp_Result), .exp_code(exp_code),
    .tag_ROB_Result(tag_ROB_Result)
  );

  alu_unit_pipe #(.DATA_W(16), .PREG_W(5), .TAG_W(5), .LAT(Lat), .EXC_OVF(1'b0)) u_dut_novf (
    .clk(clk), .rst(rst), .flush(flush), .freeze_back(freeze_back), .valid_in(valid_in),
    .op_in(op_in), .Pw_in(Pw_in), .busA_in(busA_in), .busB_in(busB_in),
    .tag_ROB_in(tag_ROB_in), .ready_in(n_ready), .busy(n_busy), .valid_Result(n_valid),
    .Pw_Result(n_pw), .Result(n_res), .exp_Result(n_exp), .exp_code(n_code),
    .tag_ROB_Result(n_tag)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] res;
    logic [1:0]  code;
    logic [4:0]  pw;
    logic [4:0]  tag;
  } exp_t;

  typedef struct packed {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [4:0]  pw;
    logic [4:0]  tag;
    logic [15:0] res;
    logic [1:0]  code;
  } vec_t;

  exp_t sb_q[$];
  exp_t mon_e;
  vec_t vecs [NVec];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected result is queued only if the op will actually be accepted at the next edge.
  task automatic drive(input logic v, input logic [2:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [4:0] pw, input logic [4:0] tag,
                       input logic [15:0] res, input logic [1:0] code);
    exp_t e;
    valid_in   = v;
    op_in      = op;
    busA_in    = a;
    busB_in    = b;
    Pw_in      = pw;
    tag_ROB_in = tag;
    if (v && rst && !freeze_back && !flush) begin
      e.res  = res;
      e.code = code;
      e.pw   = pw;
      e.tag  = tag;
      sb_q.push_back(e);
    end
  endtask

  task automatic idle();
    valid_in = 1'b0;
  endtask

  // A result is delivered when it sits on the outputs with the back end running.
  always @(negedge clk) begin
    if (rst) begin
      if (valid_Result && !freeze_back && !flush) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_result: got tag 0x%0h, expected no result", tag_ROB_Result);
        end else begin
          mon_e = sb_q.pop_front();
          check("sb_result", 32'(Result), 32'(mon_e.res));
          check("sb_code", 32'(exp_code), 32'(mon_e.code));
          check("sb_exp", 32'(exp_Result), 32'(mon_e.code != 2'd0));
          check("sb_pw", 32'(Pw_Result), 32'(mon_e.pw));
          check("sb_tag", 32'(tag_ROB_Result), 32'(mon_e.tag));
        end
      end else if (!valid_Result) begin
        check("bubble_exp", 32'({exp_Result, exp_code}), 32'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{op: OpAdd, a: 16'h1234, b: 16'h0FFF, pw: 5'd3,  tag: 5'd7,  res: 16'h2233, code: 2'd0};
    vecs[1]  = '{op: OpSub, a: 16'h0005, b: 16'h0007, pw: 5'd5,  tag: 5'd1,  res: 16'hFFFE, code: 2'd0};
    vecs[2]  = '{op: OpSlt, a: 16'hFFFF, b: 16'h0001, pw: 5'd6,  tag: 5'd2,  res: 16'h0001, code: 2'd0};
    vecs[3]  = '{op: OpSrl, a: 16'h8000, b: 16'h000F, pw: 5'd7,  tag: 5'd3,  res: 16'h0001, code: 2'd0};
    vecs[4]  = '{op: OpAdd, a: 16'h7FFF, b: 16'h0001, pw: 5'd4,  tag: 5'd4,  res: 16'h8000, code: 2'd2};
    vecs[5]  = '{op: OpAdd, a: 16'h7FFF, b: 16'h0001, pw: 5'd0,  tag: 5'd5,  res: 16'h8000, code: 2'd1};
    vecs[6]  = '{op: OpAnd, a: 16'hF0F0, b: 16'h3C3C, pw: 5'd8,  tag: 5'd6,  res: 16'h3030, code: 2'd0};
    vecs[7]  = '{op: OpOr,  a: 16'hF0F0, b: 16'h0F01, pw: 5'd9,  tag: 5'd8,  res: 16'hFFF1, code: 2'd0};
    vecs[8]  = '{op: OpXor, a: 16'hAAAA, b: 16'hFFFF, pw: 5'd10, tag: 5'd9,  res: 16'h5555, code: 2'd0};
    vecs[9]  = '{op: OpSll, a: 16'h0001, b: 16'h0013, pw: 5'd11, tag: 5'd10, res: 16'h0008, code: 2'd0};
    vecs[10] = '{op: OpSub, a: 16'h8000, b: 16'h0001, pw: 5'd12, tag: 5'd11, res: 16'h7FFF, code: 2'd2};
    vecs[11] = '{op: OpSlt, a: 16'h0001, b: 16'hFFFF, pw: 5'd13, tag: 5'd12, res: 16'h0000, code: 2'd0};
    vecs[12] = '{op: OpAdd, a: 16'hFFFF, b: 16'h0001, pw: 5'd14, tag: 5'd13, res: 16'h0000, code: 2'd0};
    vecs[13] = '{op: OpSrl, a: 16'hF00F, b: 16'h0004, pw: 5'd15, tag: 5'd14, res: 16'h0F00, code: 2'd0};
    vecs[14] = '{op: OpSlt, a: 16'h8000, b: 16'h7FFF, pw: 5'd16, tag: 5'd15, res: 16'h0001, code: 2'd0};
    vecs[15] = '{op: OpSub, a: 16'h0000, b: 16'h8000, pw: 5'd17, tag: 5'd16, res: 16'h8000, code: 2'd2};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(valid_Result), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_result", 32'(Result), 32'd0);
    check("rst_pw_tag", 32'({Pw_Result, tag_ROB_Result}), 32'd0);
    check("rst_exp", 32'({exp_Result, exp_code}), 32'd0);
    check("rst_ready", 32'(ready_in), 32'd1);
    rst = 1'b1;

    // Latency: accepted at edge 0, visible after edge 1
    drive(1'b1, OpAdd, 16'h1234, 16'h0FFF, 5'd3, 5'd7, 16'h2233, 2'd0);
    tick();
    idle();
    check("lat_early_valid", 32'(valid_Result), 32'd0);
    check("lat_early_busy", 32'(busy), 32'd1);
    tick();
    check("lat_valid", 32'(valid_Result), 32'd1);
    check("lat_result", 32'(Result), 32'h2233);
    check("lat_pw_tag", 32'({Pw_Result, tag_ROB_Result}), 32'({5'd3, 5'd7}));
    repeat (2) tick();

    // Back-to-back vector table
    for (int i = 0; i < int'(NVec); i++) begin
      drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].pw, vecs[i].tag, vecs[i].res,
            vecs[i].code);
      tick();
    end
    idle();
    repeat (Lat + 1) tick();

    // Overflow ignored when EXC_OVF=0
    drive(1'b1, OpAdd, 16'h7FFF, 16'h0001, 5'd4, 5'd22, 16'h8000, 2'd2);
    tick();
    idle();
    tick();
    check("novf_valid", 32'(n_valid), 32'd1);
    check("novf_result", 32'(n_res), 32'h8000);
    check("novf_exp", 32'({n_exp, n_code}), 32'd0);
    repeat (2) tick();

    // Freeze: A on outputs, A2 in stage 1, B presented but must not be taken
    drive(1'b1, OpXor, 16'h00FF, 16'h0F0F, 5'd20, 5'd20, 16'h0FF0, 2'd0);
    tick();
    drive(1'b1, OpOr, 16'h1000, 16'h0001, 5'd21, 5'd21, 16'h1001, 2'd0);
    tick();
    freeze_back = 1'b1;
    drive(1'b1, OpAdd, 16'h0001, 16'h0001, 5'd22, 5'd23, 16'h0002, 2'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("frz_ready", 32'(ready_in), 32'd0);
      check("frz_valid", 32'(valid_Result), 32'd1);
      check("frz_result", 32'(Result), 32'h0FF0);
      check("frz_tag", 32'(tag_ROB_Result), 32'd20);
    end
    freeze_back = 1'b0;
    idle();
    tick();
    check("rel_tag", 32'(tag_ROB_Result), 32'd21);
    tick();
    check("rel_no_dup", 32'(valid_Result), 32'd0);
    check("rel_busy", 32'(busy), 32'd0);
    tick();

    // Flush together with freeze kills both in-flight ops
    drive(1'b1, OpAnd, 16'hFFFF, 16'h1234, 5'd24, 5'd24, 16'h1234, 2'd0);
    tick();
    drive(1'b1, OpSub, 16'h0009, 16'h0004, 5'd25, 5'd25, 16'h0005, 2'd0);
    tick();
    flush = 1'b1;
    freeze_back = 1'b1;
    sb_q.delete();
    drive(1'b1, OpAdd, 16'h0002, 16'h0003, 5'd26, 5'd26, 16'h0005, 2'd0);
    tick();
    check("fl_busy", 32'(busy), 32'd0);
    check("fl_valid", 32'(valid_Result), 32'd0);
    flush = 1'b0;
    freeze_back = 1'b0;
    idle();
    repeat (3) tick();
    check("fl_quiet", 32'(valid_Result), 32'd0);

    // Asynchronous reset with the pipeline full
    drive(1'b1, OpAdd, 16'h0100, 16'h0200, 5'd27, 5'd27, 16'h0300, 2'd0);
    tick();
    drive(1'b1, OpXor, 16'h00F0, 16'h000F, 5'd28, 5'd28, 16'h00FF, 2'd0);
    tick();
    idle();
    #2;
    rst = 1'b0;
    #1;
    check("arst_valid", 32'(valid_Result), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_result", 32'(Result), 32'd0);
    check("arst_pw_tag", 32'({Pw_Result, tag_ROB_Result}), 32'd0);
    sb_q.delete();
    tick();
    rst = 1'b1;
    drive(1'b1, OpSll, 16'h0003, 16'h0002, 5'd29, 5'd29, 16'h000C, 2'd0);
    tick();
    idle();
    check("arst_lat_early", 32'(valid_Result), 32'd0);
    tick();
    check("arst_lat_valid", 32'(valid_Result), 32'd1);
    check("arst_lat_result", 32'(Result), 32'h000C);
    repeat (3) tick();

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_unit_pipe.md
Name: alu_unit_pipe

Overview:
- Parametrised successor to the single-cycle back-end adder: a LAT-stage pipelined integer ALU sitting between issue and the result bus / ROB.
- Executes one of eight ops per cycle on renamed operands and carries Pw and the ROB tag alongside the result.
- Reports a typed exception for writes to physical register 0 and for signed overflow.
- Obeys the global back-end freeze and the pipeline flush.

Parameters:
- DATA_W, 16, operand/result width (≥4, power of two).
- PREG_W, 5, physical register index width.
- TAG_W, 5, ROB tag width.
- LAT, 2, issue-to-result latency in cycles (≥1).
- EXC_OVF, 1, 1 = signed overflow on ADD/SUB raises exception; 0 = ignored.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous pipeline kill.
- freeze_back  in  1  back-end stall; holds every stage.
- valid_in  in  1  issue valid.
- op_in  in  3  opcode.
- Pw_in  in  PREG_W  destination physical register.
- busA_in  in  DATA_W  operand A.
- busB_in  in  DATA_W  operand B.
- tag_ROB_in  in  TAG_W  ROB tag.
- ready_in  out  1  unit accepts issue this cycle (= !freeze_back).
- busy  out  1  any pipeline stage holds a valid op.
- valid_Result  out  1  result valid.
- Pw_Result  out  PREG_W  destination register.
- Result  out  DATA_W  result.
- exp_Result  out  1  exception flag.
- exp_code  out  2  0 none, 1 dest-p0, 2 overflow.
- tag_ROB_Result  out  TAG_W  ROB tag.

Behaviour:
- Reset (rst=0, asynchronous): every pipeline register and every output is 0; busy=0.
- Clock priority on each edge: flush > freeze_back > advance.
  - flush=1: all stages are cleared to 0, valid and payload alike. A concurrent issue is dropped.
  - freeze_back=1: all stages hold. valid_in is ignored; the issuer must hold the op while ready_in=0.
  - Otherwise all stages shift by one. Stage 1 captures the computed op; stage LAT drives the outputs directly.
- Latency: an op accepted at edge N appears on the outputs after edge N+LAT-1 (LAT=1 reproduces the single-cycle unit).
- Throughput: one op per unfrozen cycle.
- Op encoding, all modulo 2^DATA_W:
  - 0 ADD: A+B.
  - 1 SUB: A−B.
  - 2 AND.
  - 3 OR.
  - 4 XOR.
  - 5 SLT: signed A<B → 1 else 0.
  - 6 SLL: A<<B[log2(DATA_W)-1:0].
  - 7 SRL: logical right shift, same amount field.
- Overflow: flagged for ADD/SUB only, as the two's-complement signed overflow of the DATA_W result.
- Exception, computed in stage 1:
  - Pw_in==0 with valid → code 1 (takes priority).
  - Otherwise EXC_OVF=1 and overflow with valid → code 2.
  - Otherwise code 0.
  - exp_Result = (exp_code≠0).
  - An invalid op always carries code 0.
- Invalid ops (valid_in=0) still flow through as bubbles. Their payload is don't-care; the bench checks only that valid=0 and exp=0.
- The Result is still computed on an exception. Suppressing the writeback is the ROB's responsibility.
- busy = OR of all stage valid bits and is purely combinational from the registers.
- Reset or flush asserted mid-operation discards all in-flight ops; nothing emerges afterwards.
- A flush and freeze_back in the same cycle still clears the pipeline.

Test Plan:
- DATA_W=16, LAT=2, ADD 0x1234+0x0FFF, Pw=3, tag=7, issued at edge 0 → after edge 1: valid=1, Result=0x2233, Pw=3, tag=7, exp=0; one cycle earlier valid=0.
- Back-to-back issue of SUB 5−7, SLT 0xFFFF vs 0x0001, SRL 0x8000 by 0x0F on consecutive cycles → consecutive outputs 0xFFFE, 0x0001, 0x0001.
- ADD 0x7FFF+0x0001, Pw=4 → Result=0x8000, exp=1, code=2. Repeat with EXC_OVF=0 → exp=0. ADD with Pw=0 plus overflow → code=1.
- Issue op A, then assert freeze_back for 3 cycles with valid_in=1 presented → output and stage contents are held, ready_in=0, the presented op is not accepted; after release, A emerges with no duplicate.
- Two ops in flight, flush pulsed with freeze_back=1 → next cycle busy=0 and valid_Result=0; neither op ever appears.
- rst driven low asynchronously between edges with the pipeline full → outputs are immediately 0; after release, the first new op appears at the normal latency.
